uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

Serial receive stage for the FPGA host link. It consumes the oversampled tick produced by the baud tick generator (Baud × Oversampling) and the asynchronous `rxd` pin. It recovers 8N1 frames (one start bit, DataBits data bits LSB first, one stop bit, no parity) and presents each byte as a one-cycle valid pulse to the command/matrix loader logic downstream.

## Interface

Parameters:
- `Oversampling`, default 16; ticks per bit; power of two, ≥ 8.
- `DataBits`, default 8; data bits per frame; 5–8.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset; **one clock; reset is asynchronous and active-high**.
- `baud_tick`  input  1  one-`clk`-wide pulse at Baud × Oversampling from the tick generator.
- `rxd`  input  1  raw serial line, idle high, asynchronous to `clk`.
- `data`  output  DataBits  last correctly framed byte.
- `data_valid`  output  1  one-cycle pulse; `data` is new.
- `framing_error`  output  1  one-cycle pulse; stop bit sampled low.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation

- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- State and counters advance only on `clk` edges where `baud_tick`=1. Other cycles hold everything, except that `data_valid` and `framing_error` return to 0.
- `tick_cnt` is log2(Oversampling) bits wide and wraps naturally. `bit_idx` is log2(DataBits)+1 bits wide.
- FSM states are IDLE, START, DATA, STOP, BREAK:
  - IDLE: on a tick with `rxs`=0, go to START with `tick_cnt`=0.
  - START: increment `tick_cnt` each tick. On the tick where `tick_cnt`=Oversampling/2−1, sample `rxs`:
    - 1 means a false start; go to IDLE with no output.
    - 0 means go to DATA with `tick_cnt`=0 and `bit_idx`=0.
  - DATA: increment `tick_cnt` each tick. On the tick where `tick_cnt`=Oversampling−1:
    - Shift `rxs` into the MSB of the shift register (right shift, so the LSB is received first).
    - Increment `bit_idx`.
    - After bit DataBits−1, go to STOP.
  - STOP: on the tick where `tick_cnt`=Oversampling−1, sample `rxs`:
    - 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
    - 0: pulse `framing_error`, leave `data` unchanged, go to BREAK.
  - BREAK: on a tick with `rxs`=1, go to IDLE. A held-low line therefore produces exactly one `framing_error` and no spurious frames.
- Returning to IDLE at mid-stop-bit lets back-to-back frames be received with zero idle time.
- `data_valid` and `framing_error` are never high together.

## Timing

- Reset values: `data`=0, `data_valid`=0, `framing_error`=0, `busy`=0. The FSM is in IDLE, counters are 0, and the shift register is 0.
- Start detection:
  - Let T0 be the first tick at which `rxs`=0 in IDLE.
  - `rxs` lags `rxd` by 2–3 `clk` cycles.
- Sample points, in ticks after T0:
  - Start check at Oversampling/2.
  - Data bit i at Oversampling/2 + (i+1)·Oversampling.
  - Stop bit at Oversampling/2 + (DataBits+1)·Oversampling. This is 152 ticks for 16/8.
- `data`, `data_valid`, `framing_error` and `busy` are registered. They change on the `clk` edge that processes the sampling tick.
- `data_valid` and `framing_error` are high for exactly one `clk`.
- `busy` rises on the T0 edge. It falls on the edge that enters IDLE.
- Reset asserted mid-frame: immediate return to reset values. No `data_valid` or `framing_error` is issued for the partial frame.
- `baud_tick` stalled (held 0): the FSM freezes and no timeout applies.
- `baud_tick` held high: this is illegal input, and behaviour is unspecified.

## Structure

- Shared package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - `UART_DEFAULT_OVERSAMPLING`=16 and `UART_DEFAULT_DATABITS`=8.
  - These are shared with the future transmitter.
- One sub-module `sync_2ff`: a parameterized reset-value double-flop synchronizer, reused for other async inputs.
- `uart_rx_oversampled` holds the FSM, counters and shift register. It does not instantiate the tick generator; the top level wires the tick in.

## Test plan

Common setup: 50 MHz `clk`, tick generator at 115200 × 16, serial driver in the bench.

- Send 0xA5 with 8N1 framing. Expect `data`=0xA5 and a single `data_valid` pulse 152 ticks (±1) after the start edge. `busy` is low afterwards.
- Send 0x00 then 0xFF back-to-back with no idle bits. Expect two `data_valid` pulses with `data`=0x00, then 0xFF, and no `framing_error`.
- Drive a 0 glitch of 5 ticks on an idle line. Expect `busy` high then low, and no `data_valid` or `framing_error`.
- Send frame 0x3C with the stop bit forced to 0, then hold `rxd` low for 30 bit times, then release. Expect:
  - exactly one `framing_error`;
  - `data` still holding the previous value;
  - after release, the next frame 0x81 is received correctly.
- Assert `rst` during data bit 4 of frame 0x5A. Expect outputs at reset values immediately. The following frame 0x12 is received correctly.
- Gate `baud_tick` off for 1000 `clk` cycles mid-frame, then resume. Expect the frame 0xC3 still received correctly once ticks resume.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_pkg                                                   |
// | Description : Shared UART definitions for the receive and (future)       |
// |               transmit paths: receiver state encoding and the default    |
// |               frame parameters.                                          |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DEFAULT_OVERSAMPLING = 16;
  localparam int UART_DEFAULT_DATABITS     = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_2ff                                                   |
// | Description : Two-flop synchronizer for asynchronous inputs. Both stages |
// |               reset to RESET_VAL so an idle line never looks active      |
// |               while the synchronizer is being flushed after reset.       |
// | Ports       : clk      - destination clock                               |
// |               rst      - asynchronous active-high reset                  |
// |               i_async  - asynchronous input                              |
// |               o_sync   - synchronized output (2 clk latency)             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_oversampled                                        |
// | Description : 8N1-style UART receiver driven by an external oversampled  |
// |               baud tick. Recovers start/data/stop framing, presents each |
// |               good byte with a one-cycle data_valid pulse and reports a  |
// |               low stop bit with a one-cycle framing_error pulse.         |
// | Ports       : clk           - system clock                               |
// |               rst           - asynchronous active-high reset             |
// |               baud_tick     - one-clk pulse at Baud x Oversampling       |
// |               rxd           - raw serial line, idle high, asynchronous   |
// |               data          - last correctly framed byte                 |
// |               data_valid    - one-cycle pulse, data is new               |
// |               framing_error - one-cycle pulse, stop bit sampled low      |
// |               busy          - high whenever the receiver is not idle     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int Oversampling = UART_DEFAULT_OVERSAMPLING,
  parameter int DataBits     = UART_DEFAULT_DATABITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_tick,
  input  logic                rxd,
  output logic [DataBits-1:0] data,
  output logic                data_valid,
  output logic                framing_error,
  output logic                busy
);

  localparam int c_TICK_W = $clog2(Oversampling);
  localparam int c_IDX_W  = $clog2(DataBits) + 1;

  // Start is re-checked half a bit in; every later sample lands one full
  // bit after the previous one, i.e. at the centre of each bit cell.
  localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(Oversampling / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(Oversampling - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DataBits - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);

  logic w_rxs;

  rx_state_t            r_state,   w_state_nxt;
  logic [c_TICK_W-1:0]  r_tick,    w_tick_nxt;
  logic [c_IDX_W-1:0]   r_idx,     w_idx_nxt;
  logic [DataBits-1:0]  r_shift,   w_shift_nxt;
  logic [DataBits-1:0]  r_data,    w_data_nxt;
  logic                 r_valid,   w_valid_nxt;
  logic                 r_ferr,    w_ferr_nxt;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rxd_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rxd),
    .o_sync  (w_rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Everything holds between ticks; only the two strobes self-clear.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    if (baud_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = START;
            w_tick_nxt  = '0;
          end
        end

        START: begin
          w_tick_nxt = r_tick + c_TICK_ONE;
          if (r_tick == c_TICK_HALF) begin
            if (w_rxs) begin
              // Line went back high before mid-start: treat as a glitch.
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = DATA;
              w_tick_nxt  = '0;
              w_idx_nxt   = '0;
            end
          end
        end

        DATA: begin
          // The tick counter wraps on its own, so no reload is needed
          // between bits or when moving on to the stop bit.
          w_tick_nxt = r_tick + c_TICK_ONE;
          if (r_tick == c_TICK_LAST) begin
            w_shift_nxt = {w_rxs, r_shift[DataBits-1:1]};
            w_idx_nxt   = r_idx + c_IDX_ONE;
            if (r_idx == c_IDX_LAST) begin
              w_state_nxt = STOP;
            end
          end
        end

        STOP: begin
          w_tick_nxt = r_tick + c_TICK_ONE;
          if (r_tick == c_TICK_LAST) begin
            // Leaving at mid-stop-bit leaves half a bit of margin to
            // catch a start edge that follows with no idle time.
            if (w_rxs) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = BREAK;
            end
          end
        end

        BREAK: begin
          // Park here until the line is released so a held-low line
          // cannot be mistaken for a stream of new start bits.
          if (w_rxs) begin
            w_state_nxt = IDLE;
          end
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign data          = r_data;
  assign data_valid    = r_valid;
  assign framing_error = r_ferr;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_oversampled                                     |
// | Description : Self-checking bench for uart_rx_oversampled. A serial      |
// |               driver sends frames aligned to the baud tick and records   |
// |               the expected receiver event per frame in a queue; a        |
// |               monitor pops and compares on every strobe from the DUT.    |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_oversampled;

  localparam int OS  = 16;
  localparam int DB  = 8;
  localparam int DIV = 27;  // 50 MHz / (115200 * 16) rounded

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rxd = 1'b1;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          framing_error;
  logic          busy;

  bit tick_en = 1'b1;
  int n_ticks = 0;
  int evt_tick = 0;
  int start_tick = 0;
  int checks = 0;
  int failures = 0;

  // Expected receiver event for one frame: a good byte, or a framing
  // error during which data must still show the last good byte.
  typedef struct {
    bit            is_err;
    logic [DB-1:0] d;
  } exp_t;

  exp_t          sb[$];
  logic [DB-1:0] last_good = '0;

  uart_rx_oversampled #(
    .Oversampling (OS),
    .DataBits     (DB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rxd           (rxd),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #10 clk = ~clk;

  initial begin
    forever begin
      repeat (DIV - 1) @(posedge clk);
      #1 baud_tick = tick_en;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (baud_tick) n_ticks <= n_ticks + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (data_valid || framing_error) begin
      check("strobe_exclusive", {31'd0, data_valid & framing_error}, 32'd0);
      evt_tick = n_ticks;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got valid=%0b ferr=%0b data=%0h expected no event",
                 data_valid, framing_error, data);
      end else begin
        e = sb.pop_front();
        check("event_kind_is_err", {31'd0, framing_error}, {31'd0, e.is_err});
        check("event_data", {24'd0, data}, {24'd0, e.d});
      end
    end
  end

  // Waits for n baud ticks, returning just after the tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic idle_bits(input int nbits);
    rxd = 1'b1;
    wait_ticks(nbits * OS);
  endtask

  // Sends start, DB data bits LSB first and a stop bit of the given value.
  task automatic send_frame(input logic [DB-1:0] b, input bit stop_ok, input bit hold_low);
    exp_t e;
    if (stop_ok) begin
      e.is_err  = 1'b0;
      e.d       = b;
      last_good = b;
    end else begin
      e.is_err = 1'b1;
      e.d      = last_good;
    end
    sb.push_back(e);
    start_tick = n_ticks;
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rxd = b[i];
      wait_ticks(OS);
    end
    rxd = stop_ok;
    wait_ticks(OS);
    rxd = hold_low ? 1'b0 : 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) wait_ticks(1);
    check(name, sb.size(), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DB-1:0] rb;
    bit            rok;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_ferr", {31'd0, framing_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle_bits(1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single frame with latency check.
    send_frame(8'hA5, 1'b1, 1'b0);
    drain("a5_received");
    check("a5_latency_in_151_153",
          {31'd0, ((evt_tick - start_tick) >= 151) && ((evt_tick - start_tick) <= 153)}, 32'd1);
    wait_ticks(4);
    check("a5_busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back frames, no idle time.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(1);
    drain("b2b_received");

    // Short glitch on an idle line.
    rxd = 1'b0;
    wait_ticks(5);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    wait_ticks(OS);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);

    // Bad stop bit followed by a long break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_ticks(30 * OS);
    check("break_still_busy", {31'd0, busy}, 32'd1);
    idle_bits(2);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(1);
    drain("break_recovery");

    // Reset in the middle of data bit 4 of 0x5A.
    rb = 8'h5A;
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rxd = rb[i];
      wait_ticks(OS);
    end
    rxd = rb[4];
    wait_ticks(OS / 2);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #2;
    check("midframe_reset_data", {24'd0, data}, 32'd0);
    check("midframe_reset_busy", {31'd0, busy}, 32'd0);
    check("midframe_reset_valid", {31'd0, data_valid}, 32'd0);
    check("midframe_reset_ferr", {31'd0, framing_error}, 32'd0);
    rxd = 1'b1;
    last_good = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_bits(1);
    send_frame(8'h12, 1'b1, 1'b0);
    idle_bits(1);
    drain("after_reset_frame");

    // Tick stall mid-frame.
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        wait_ticks(60);
        tick_en = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        check("stall_busy_frozen", {31'd0, busy}, 32'd1);
        tick_en = 1'b1;
      end
    join
    idle_bits(1);
    drain("stall_frame");

    // Randomized frames, occasionally with a bad stop bit.
    for (int k = 0; k < 4; k++) begin
      rb  = DB'($urandom);
      rok = ($urandom_range(3) != 0);
      send_frame(rb, rok, 1'b0);
      idle_bits(rok ? int'($urandom_range(2)) : 1);
    end
    idle_bits(1);
    drain("random_frames");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
